// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer and lock supervisor, running on the 50 MHz reference clock.
// Pulses the PLL reset, waits for lock with timeout/retry, qualifies lock, then releases the core.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             lock_lost,
    output logic             timeout_err,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int unsigned CTR_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned CTR_MAX   = (CTR_MAX_A > LOCK_TIMEOUT) ? CTR_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CTR_W     = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;

    localparam logic [CTR_W-1:0] RST_LAST     = CTR_W'(RST_CYCLES - 1);
    localparam logic [CTR_W-1:0] STABLE_LAST  = CTR_W'(LOCK_STABLE - 1);
    localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [1:0]         sync_q, sync_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic               lock_lost_q, lock_lost_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   loss_count_q, loss_count_d;
    logic               locked_s;

    assign locked_s = sync_q[1];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET_PLL;
            ctr_q         <= '0;
            sync_q        <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            loss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            sync_q        <= sync_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            lock_lost_q   <= lock_lost_d;
            timeout_err_q <= timeout_err_d;
            loss_count_q  <= loss_count_d;
        end
    end

    // Next state; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        sync_d        = {sync_q[0], pll_locked};
        lock_lost_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        loss_count_d  = loss_count_q;

        if ((state_q == S_RUN) && !locked_s) begin
            // Loss wins over a same-cycle relock request, but the request still clears the flag.
            lock_lost_d = 1'b1;
            if (loss_count_q != LOSS_MAX) begin
                loss_count_d = loss_count_q + CNT_W'(1);
            end
            if (relock_req) begin
                timeout_err_d = 1'b0;
            end
            state_d = S_RESET_PLL;
            ctr_d   = '0;
        end else if (relock_req) begin
            timeout_err_d = 1'b0;
            state_d       = S_RESET_PLL;
            ctr_d         = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (ctr_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        ctr_d   = '0;
                    end else begin
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                        ctr_d   = '0;
                    end else if (ctr_q == TIMEOUT_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_RESET_PLL;
                        ctr_d         = '0;
                    end else begin
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        ctr_d   = '0;
                    end else if (ctr_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        ctr_d   = '0;
                    end else begin
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                end
                S_RUN: begin
                    ctr_d = '0;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    ctr_d   = '0;
                end
            endcase
        end

        pll_rst_d   = (state_d == S_RESET_PLL);
        ready_d     = (state_d == S_RUN);
        sys_rst_n_d = (state_d == S_RUN);
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign timeout_err = timeout_err_q;
    assign loss_count  = loss_count_q;
    assign state       = state_q;

endmodule
